cmd_executor: RTL and testbench

CMD_EXECUTOR -- requirements
Module: cmd_executor

---
 rtl/car_cmd_pkg.sv | 75 +++++++
 rtl/sync_2ff.sv | 25 ++
 rtl/cmd_executor.sv | 221 ++++++++++++++++++++++
 tb/tb_cmd_executor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_cmd_pkg.sv
// Shared command codes, executor state encoding and small helpers used by
// the car command executor.
package car_cmd_pkg;

  // Width of the shared EXEC/GAP down-counter
  localparam int unsigned CNT_W = 32;

  // Number of drive outputs towards the car
  localparam int unsigned NUM_DRIVES = 6;

  // Bit positions of each drive level inside the packed drive vector
  localparam int DRV_FWD     = 0;
  localparam int DRV_BWD     = 1;
  localparam int DRV_LEFT    = 2;
  localparam int DRV_RIGHT   = 3;
  localparam int DRV_PLACE   = 4;
  localparam int DRV_DESTROY = 5;

  // Command codes as presented on cmd_code
  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_FWD     = 3'd1,
    CMD_BWD     = 3'd2,
    CMD_LEFT    = 3'd3,
    CMD_RIGHT   = 3'd4,
    CMD_PLACE   = 3'd5,
    CMD_DESTROY = 3'd6,
    CMD_RSVD    = 3'd7
  } cmd_code_e;

  // Executor states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_GAP  = 2'd2
  } exec_state_e;

  // True for codes that drive an output (1..6); NOP and reserved are errors
  function automatic logic is_exec_cmd(cmd_code_e c);
    return (c != CMD_NOP) && (c != CMD_RSVD);
  endfunction

  // True for the two commands that a detector may cut short
  function automatic logic is_move_cmd(cmd_code_e c);
    return (c == CMD_FWD) || (c == CMD_BWD);
  endfunction

  // One-hot drive pattern for a command; all-zero for NOP/reserved
  function automatic logic [NUM_DRIVES-1:0] drive_onehot(cmd_code_e c);
    logic [NUM_DRIVES-1:0] v;
    v = '0;
    case (c)
      CMD_FWD:     v[DRV_FWD]     = 1'b1;
      CMD_BWD:     v[DRV_BWD]     = 1'b1;
      CMD_LEFT:    v[DRV_LEFT]    = 1'b1;
      CMD_RIGHT:   v[DRV_RIGHT]   = 1'b1;
      CMD_PLACE:   v[DRV_PLACE]   = 1'b1;
      CMD_DESTROY: v[DRV_DESTROY] = 1'b1;
      default:     v = '0;
    endcase
    return v;
  endfunction

  // Counter load value for a duration in cycles; a duration of 0 behaves as 1
  function automatic logic [CNT_W-1:0] load_value(int unsigned cycles);
    logic [CNT_W-1:0] v;
    if (cycles == 0) begin
      v = '0;
    end else begin
      v = cycles - 32'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous level through two flops to settle metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/cmd_executor.sv
// Car command executor: accepts one command at a time, holds the matching
// drive output for a fixed number of cycles, then enforces a quiet gap
// before signalling completion. Moves can be cut short by obstacle detectors.
module cmd_executor
  import car_cmd_pkg::*;
#(
  parameter int unsigned MOVE_CYCLES  = 50_000_000,
  parameter int unsigned TURN_CYCLES  = 25_000_000,
  parameter int unsigned PULSE_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES   = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_code,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic       cmd_abort,
  output logic       cmd_err,
  input  logic       front_detector,
  input  logic       back_detector,
  output logic       move_forward_signal,
  output logic       move_backward_signal,
  output logic       turn_left_signal,
  output logic       turn_right_signal,
  output logic       place_barrier_signal,
  output logic       destroy_barrier_signal
);

  // Counter preload values (duration - 1, with a zero duration acting as 1)
  localparam logic [CNT_W-1:0] MOVE_LOAD  = load_value(MOVE_CYCLES);
  localparam logic [CNT_W-1:0] TURN_LOAD  = load_value(TURN_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LOAD = load_value(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD   = load_value(GAP_CYCLES);

  // Index of each detector in the synchronizer bank
  localparam int DET_FRONT = 0;
  localparam int DET_BACK  = 1;
  localparam int NUM_DET   = 2;

  // Registered state
  exec_state_e           r_state;
  cmd_code_e             r_cmd;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_DRIVES-1:0] r_drive;
  logic                  r_done;
  logic                  r_abort;
  logic                  r_err;

  // Next-state values
  exec_state_e           w_state_next;
  cmd_code_e             w_cmd_next;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [NUM_DRIVES-1:0] w_drive_next;
  logic                  w_done_next;
  logic                  w_abort_next;
  logic                  w_err_next;

  // Decoded conditions
  cmd_code_e             w_code_in;
  logic                  w_accept;
  logic                  w_accept_exec;
  logic                  w_cnt_zero;
  logic                  w_abort_cond;
  logic [NUM_DET-1:0]    w_det_async;
  logic [NUM_DET-1:0]    w_det_sync;

  // Counter preload for the EXEC phase of a given command
  function automatic logic [CNT_W-1:0] exec_load(cmd_code_e c);
    logic [CNT_W-1:0] v;
    case (c)
      CMD_FWD, CMD_BWD:     v = MOVE_LOAD;
      CMD_LEFT, CMD_RIGHT:  v = TURN_LOAD;
      default:              v = PULSE_LOAD;
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------------
  // Detector synchronizers, one per obstacle input
  // ---------------------------------------------------------------------
  assign w_det_async[DET_FRONT] = front_detector;
  assign w_det_async[DET_BACK]  = back_detector;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DET; gi++) begin : g_det_sync
      sync_2ff u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (w_det_async[gi]),
        .o_sync  (w_det_sync[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Decoded conditions shared by the next-state and output logic
  // ---------------------------------------------------------------------
  assign w_code_in     = cmd_code_e'(cmd_code);
  assign w_accept      = cmd_valid && (r_state == ST_IDLE);
  assign w_accept_exec = w_accept && is_exec_cmd(w_code_in);
  assign w_cnt_zero    = (r_cnt == '0);

  // A detector only matters while the matching move is being driven
  assign w_abort_cond  = (r_state == ST_EXEC) &&
                         (((r_cmd == CMD_FWD) && w_det_sync[DET_FRONT]) ||
                          ((r_cmd == CMD_BWD) && w_det_sync[DET_BACK]));

  // ---------------------------------------------------------------------
  // State register: all executor state, outputs registered here as well
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cmd   <= CMD_NOP;
      r_cnt   <= '0;
      r_drive <= '0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cmd   <= w_cmd_next;
      r_cnt   <= w_cnt_next;
      r_drive <= w_drive_next;
      r_done  <= w_done_next;
      r_abort <= w_abort_next;
      r_err   <= w_err_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        // NOP/reserved are answered in place and never leave IDLE
        if (w_accept_exec) begin
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_abort_cond || w_cnt_zero) begin
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_cnt_zero) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic: counter, latched command, drive levels and status pulses
  // ---------------------------------------------------------------------
  always_comb begin
    w_cmd_next   = r_cmd;
    w_cnt_next   = r_cnt;
    w_drive_next = '0;
    w_done_next  = 1'b0;
    w_abort_next = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cmd_next = w_code_in;
          if (w_accept_exec) begin
            w_cnt_next   = exec_load(w_code_in);
            w_drive_next = drive_onehot(w_code_in);
          end else begin
            w_err_next  = 1'b1;
            w_done_next = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (w_abort_cond) begin
          // Drop the drive immediately and still serve the full gap
          w_abort_next = 1'b1;
          w_cnt_next   = GAP_LOAD;
        end else if (w_cnt_zero) begin
          w_cnt_next = GAP_LOAD;
        end else begin
          w_cnt_next   = r_cnt - 1'b1;
          w_drive_next = r_drive;
        end
      end
      ST_GAP: begin
        if (w_cnt_zero) begin
          w_done_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_cnt_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Port mapping
  // ---------------------------------------------------------------------
  assign cmd_ready              = (r_state == ST_IDLE);
  assign cmd_done               = r_done;
  assign cmd_abort              = r_abort;
  assign cmd_err                = r_err;
  assign move_forward_signal    = r_drive[DRV_FWD];
  assign move_backward_signal   = r_drive[DRV_BWD];
  assign turn_left_signal       = r_drive[DRV_LEFT];
  assign turn_right_signal      = r_drive[DRV_RIGHT];
  assign place_barrier_signal   = r_drive[DRV_PLACE];
  assign destroy_barrier_signal = r_drive[DRV_DESTROY];

endmodule

// File: tb/tb_cmd_executor.sv
// Directed testbench for cmd_executor with short durations
// (MOVE=8, TURN=4, PULSE=2, GAP=3). Cycle c is the clock period that starts
// at the c-th rising edge after the acceptance edge; outputs are sampled on
// the falling edge inside that period.
module tb_cmd_executor;

  localparam int MOVE  = 8;
  localparam int TURN  = 4;
  localparam int PULSE = 2;
  localparam int GAP   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_code = 3'd0;
  logic       front_detector = 1'b0;
  logic       back_detector = 1'b0;
  logic       cmd_ready, cmd_done, cmd_abort, cmd_err;
  logic       move_forward_signal, move_backward_signal;
  logic       turn_left_signal, turn_right_signal;
  logic       place_barrier_signal, destroy_barrier_signal;

  int checks = 0;
  int errors = 0;

  // Observed vector: {drives[5:0] (destroy..fwd), done, abort, err, ready}
  logic [5:0] drv;
  logic [9:0] obs;
  assign drv = {destroy_barrier_signal, place_barrier_signal, turn_right_signal,
                turn_left_signal, move_backward_signal, move_forward_signal};
  assign obs = {drv, cmd_done, cmd_abort, cmd_err, cmd_ready};

  cmd_executor #(
    .MOVE_CYCLES  (MOVE),
    .TURN_CYCLES  (TURN),
    .PULSE_CYCLES (PULSE),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .cmd_valid              (cmd_valid),
    .cmd_code               (cmd_code),
    .cmd_ready              (cmd_ready),
    .cmd_done               (cmd_done),
    .cmd_abort              (cmd_abort),
    .cmd_err                (cmd_err),
    .front_detector         (front_detector),
    .back_detector          (back_detector),
    .move_forward_signal    (move_forward_signal),
    .move_backward_signal   (move_backward_signal),
    .turn_left_signal       (turn_left_signal),
    .turn_right_signal      (turn_right_signal),
    .place_barrier_signal   (place_barrier_signal),
    .destroy_barrier_signal (destroy_barrier_signal)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 10'b000000_0001) begin
      errors++;
      $display("FAIL reset_during: got %b expected %b", obs, 10'b000000_0001);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 10'b000000_0001) begin
      errors++;
      $display("FAIL reset_after: got %b expected %b", obs, 10'b000000_0001);
    end
    $display("reset: checked in-reset and post-reset state");
  endtask

  // FWD runs full length: drive cycles 1-8, gap 9-11, done/ready at 12
  task automatic test_fwd;
    logic [9:0] exp;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL fwd_ready_c0: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_code  = 3'd1;
    for (int c = 1; c <= MOVE + GAP + 1; c++) begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      exp = '0;
      if (c <= MOVE) exp[9:4] = 6'b000001;
      if (c == MOVE + GAP + 1) exp[3:0] = 4'b1001;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL fwd cycle %0d: got %b expected %b", c, obs, exp);
      end
    end
    $display("fwd: full-length forward move");
  endtask

  // Front detector raised in cycle 3 -> drive falls at 6 with abort, done at 9
  task automatic test_abort;
    logic [9:0] exp;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_code  = 3'd1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      if (c == 3) front_detector = 1'b1;
      @(negedge clk);
      exp = '0;
      if (c <= 5) exp[9:4] = 6'b000001;
      if (c == 6) exp[2] = 1'b1;
      if (c == 9) exp[3:0] = 4'b1001;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort cycle %0d: got %b expected %b", c, obs, exp);
      end
    end
    front_detector = 1'b0;
    repeat (3) @(negedge clk);
    $display("abort: forward move cut by front detector");
  endtask

  // NOP and reserved codes: err+done at cycle 1, stay ready, no drive
  task automatic test_reserved;
    logic [2:0] codes [2];
    logic [9:0] exp;
    codes[0] = 3'd7;
    codes[1] = 3'd0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_code  = codes[k];
      for (int c = 1; c <= 2; c++) begin
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        exp = (c == 1) ? 10'b000000_1011 : 10'b000000_0001;
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL reserved code %0d cycle %0d: got %b expected %b",
                   codes[k], c, obs, exp);
        end
      end
      $display("reserved: code %0d rejected with err", codes[k]);
    end
  endtask

  // Turn and barrier ignore detectors: LEFT with back high, DESTROY with both
  task automatic test_turn_ignores_detector;
    logic [2:0] codes [2];
    logic [5:0] onehot [2];
    int         durs [2];
    logic [9:0] exp;
    codes[0] = 3'd3; onehot[0] = 6'b000100; durs[0] = TURN;
    codes[1] = 3'd6; onehot[1] = 6'b100000; durs[1] = PULSE;
    back_detector = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) front_detector = 1'b1;
      repeat (3) @(negedge clk);
      cmd_valid = 1'b1;
      cmd_code  = codes[k];
      for (int c = 1; c <= durs[k] + GAP + 1; c++) begin
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        exp = '0;
        if (c <= durs[k]) exp[9:4] = onehot[k];
        if (c == durs[k] + GAP + 1) exp[3:0] = 4'b1001;
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL nodet code %0d cycle %0d: got %b expected %b",
                   codes[k], c, obs, exp);
        end
      end
      $display("nodet: code %0d unaffected by detectors", codes[k]);
    end
    back_detector  = 1'b0;
    front_detector = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Back detector already high: BWD drives 1 cycle, abort at 2, done at 5
  task automatic test_early_abort;
    logic [9:0] exp;
    back_detector = 1'b1;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_code  = 3'd2;
    for (int c = 1; c <= 2 + GAP; c++) begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      exp = '0;
      if (c == 1) exp[9:4] = 6'b000010;
      if (c == 2) exp[2] = 1'b1;
      if (c == 2 + GAP) exp[3:0] = 4'b1001;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL early_abort cycle %0d: got %b expected %b", c, obs, exp);
      end
    end
    back_detector = 1'b0;
    repeat (3) @(negedge clk);
    $display("early_abort: backward move aborted on first cycle");
  endtask

  // Reset in cycle 5 of FWD kills it; RIGHT accepted right after release
  task automatic test_reset_mid;
    logic [9:0] exp;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_code  = 3'd1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 10'b000000_0001) begin
      errors++;
      $display("FAIL reset_mid_async: got %b expected %b", obs, 10'b000000_0001);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    cmd_valid = 1'b1;
    cmd_code  = 3'd4;
    for (int c = 1; c <= TURN + GAP + 1; c++) begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      exp = '0;
      if (c <= TURN) exp[9:4] = 6'b001000;
      if (c == TURN + GAP + 1) exp[3:0] = 4'b1001;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_mid_next cycle %0d: got %b expected %b", c, obs, exp);
      end
    end
    $display("reset_mid: command discarded, next command accepted");
  endtask

  // PLACE with cmd_valid held: accepts at 0 and 6, done at 6 and 12
  task automatic test_back_to_back;
    logic [9:0] exp;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_code  = 3'd5;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp = '0;
      if (c == 1 || c == 2 || c == 7 || c == 8) exp[9:4] = 6'b010000;
      if (c == 6 || c == 12) exp[3:0] = 4'b1001;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs, exp);
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 10'b000000_0001) begin
      errors++;
      $display("FAIL back_to_back_idle: got %b expected %b", obs, 10'b000000_0001);
    end
    $display("back_to_back: two PLACE commands six cycles apart");
  endtask

  initial begin
    test_reset();
    test_fwd();
    test_abort();
    test_reserved();
    test_turn_ignores_detector();
    test_early_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
